// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline control slice.
package mips_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Mult/div occupancy tracker: IDLE/BUSY FSM with a down-counter, producing md_busy and a
// one-cycle md_done on the last busy cycle.
//
// state   | meaning
// MD_IDLE | unit free, waiting for a start
// MD_BUSY | operation in flight, counter holds remaining busy cycles minus one
module md_busy_tracker
  import mips_pipe_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start seen while busy is a protocol violation and is simply ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) state_d = MD_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = rst_n && (state_q == MD_BUSY);
    done = busy && (cnt_q == '0);
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller: load-use and mult/div stalls, taken-branch flush.
// Optional saturating stall/flush performance counters under HAZARD_PERF_CNT_EN.
module hazard_stall_controller
  import mips_pipe_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6,
  parameter int PERF_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0] IDEX_RegRt,
  input  logic [REG_ADDR_W-1:0] IFID_RegRs,
  input  logic [REG_ADDR_W-1:0] IFID_RegRt,
  input  logic                  IFID_UsesRt,
  input  logic                  IFID_IsMd,
  input  logic                  IFID_ReadsHiLo,
  input  logic                  IDEX_MdStart,
  input  logic                  EX_BranchTaken,
  output logic                  PC_Write,
  output logic                  IFID_Write,
  output logic                  IFID_Flush,
  output logic                  IDEX_Bubble,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PERF_W-1:0]     stall_cycles,
  output logic [PERF_W-1:0]     flush_cycles,
`endif
  output logic                  md_busy,
  output logic                  md_done
);

  logic load_use, md_stall, stall;

  md_busy_tracker #(
    .MD_CYCLES (MD_CYCLES),
    .CNT_W     (CNT_W)
  ) u_md_busy_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .start (IDEX_MdStart),
    .busy  (md_busy),
    .done  (md_done)
  );

  always_comb begin
    load_use = IDEX_MemRead && (IDEX_RegRt != REG_ZERO) &&
               ((IDEX_RegRt == IFID_RegRs) || (IFID_UsesRt && (IDEX_RegRt == IFID_RegRt)));
    md_stall = md_busy && (IFID_IsMd || IFID_ReadsHiLo);
    stall    = load_use || md_stall;
  end

  // Taken branch wins over a stall: the stalled instruction in ID is squashed anyway.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    if (!rst_n) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (EX_BranchTaken) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (stall) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else if (EX_BranchTaken) begin
      if (flush_cycles != '1) flush_cycles <= flush_cycles + PERF_W'(1);
    end else if (stall) begin
      if (stall_cycles != '1) stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: vector table, directed multi-cycle
// sequences and randomized traffic against a cycles-remaining reference model.
module tb_hazard_stall_controller;

  localparam int MD_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       IDEX_MemRead;
  logic [4:0] IDEX_RegRt, IFID_RegRs, IFID_RegRt;
  logic       IFID_UsesRt, IFID_IsMd, IFID_ReadsHiLo, IDEX_MdStart, EX_BranchTaken;
  logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, md_busy, md_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  hazard_stall_controller #(.MD_CYCLES(MD_CYCLES), .CNT_W(3), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegRt(IDEX_RegRt),
    .IFID_RegRs(IFID_RegRs), .IFID_RegRt(IFID_RegRt), .IFID_UsesRt(IFID_UsesRt),
    .IFID_IsMd(IFID_IsMd), .IFID_ReadsHiLo(IFID_ReadsHiLo),
    .IDEX_MdStart(IDEX_MdStart), .EX_BranchTaken(EX_BranchTaken),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
`endif
    .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n;
    logic       mem_read;
    logic [4:0] idex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_md;
    logic       reads_hilo;
    logic       md_start;
    logic       br;
  } vec_t;

  typedef struct packed {
    vec_t       v;
    logic [5:0] exp;   // {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, md_busy, md_done}
  } tv_t;

  int n_checks = 0;
  int n_fail   = 0;
  int proto_viol = 0;
  int model_rem = 0;     // busy cycles the mult/div unit still has ahead of it
  int model_stall = 0;
  int model_flush = 0;

  // Start while busy must never happen; this watcher records every occurrence.
  always @(negedge clk)
    if (rst_n && IDEX_MdStart && md_busy) begin
      proto_viol++;
      $display("note: IDEX_MdStart asserted while mult/div busy (protocol violation) at %0t", $time);
    end

  function automatic vec_t mk(logic r, logic mr, logic [4:0] irt, logic [4:0] rs,
                              logic [4:0] rt, logic ur, logic md, logic hl, logic st, logic br);
    vec_t v;
    v.rst_n = r; v.mem_read = mr; v.idex_rt = irt; v.rs = rs; v.rt = rt; v.uses_rt = ur;
    v.is_md = md; v.reads_hilo = hl; v.md_start = st; v.br = br;
    return v;
  endfunction

  function automatic logic model_stall_term(vec_t v);
    logic lu, ms;
    lu = v.mem_read && (v.idex_rt != 5'd0) &&
         (v.idex_rt == v.rs || (v.uses_rt && v.idex_rt == v.rt));
    ms = (model_rem > 0) && (v.is_md || v.reads_hilo);
    return lu || ms;
  endfunction

  function automatic logic [5:0] model_out(vec_t v);
    logic b, d;
    b = model_rem > 0;
    d = model_rem == 1;
    if (!v.rst_n)               return 6'b001100;
    if (v.br)                   return {4'b1111, b, d};
    if (model_stall_term(v))    return {4'b0001, b, d};
    return {4'b1100, b, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; IDEX_MemRead = v.mem_read; IDEX_RegRt = v.idex_rt;
    IFID_RegRs = v.rs; IFID_RegRt = v.rt; IFID_UsesRt = v.uses_rt; IFID_IsMd = v.is_md;
    IFID_ReadsHiLo = v.reads_hilo; IDEX_MdStart = v.md_start; EX_BranchTaken = v.br;
  endtask

  // One clock: apply, sample at negedge, then advance the reference model at the edge.
  task automatic run_cycle(input vec_t v, input logic [5:0] exp_hand, input bit use_model,
                           input string name);
    logic [5:0] exp;
    drive(v);
    exp = use_model ? model_out(v) : exp_hand;
    @(negedge clk);
    check(name, {26'd0, PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, md_busy, md_done},
          {26'd0, exp});
    @(posedge clk);
    if (!v.rst_n) begin
      model_rem = 0; model_stall = 0; model_flush = 0;
    end else begin
      if (v.br) model_flush++;
      else if (model_stall_term(v)) model_stall++;
      if (model_rem > 0) model_rem--;
      else if (v.md_start) model_rem = MD_CYCLES;
    end
    #1;
  endtask

  tv_t tvec[12];
  vec_t nop, rst, st, hilo;

  initial begin
    nop  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    st   = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    hilo = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    tvec[0]  = '{v: rst,                                  exp: 6'b001100};
    tvec[1]  = '{v: nop,                                  exp: 6'b110000};
    tvec[2]  = '{v: mk(1, 1, 8, 8, 0, 0, 0, 0, 0, 0),     exp: 6'b000100};
    tvec[3]  = '{v: mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0),     exp: 6'b110000};
    tvec[4]  = '{v: mk(1, 1, 8, 3, 8, 0, 0, 0, 0, 0),     exp: 6'b110000};
    tvec[5]  = '{v: mk(1, 1, 8, 3, 8, 1, 0, 0, 0, 0),     exp: 6'b000100};
    tvec[6]  = '{v: mk(1, 0, 8, 8, 8, 1, 0, 0, 0, 0),     exp: 6'b110000};
    tvec[7]  = '{v: mk(1, 1, 8, 8, 0, 0, 0, 0, 0, 1),     exp: 6'b111100};
    tvec[8]  = '{v: mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1),     exp: 6'b111100};
    tvec[9]  = '{v: mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0),     exp: 6'b110000};
    tvec[10] = '{v: hilo,                                 exp: 6'b110000};
    tvec[11] = '{v: mk(1, 1, 31, 4, 31, 1, 0, 0, 0, 0),   exp: 6'b000100};

    drive(rst);
    for (int i = 0; i < 12; i++) run_cycle(tvec[i].v, tvec[i].exp, 0, $sformatf("table[%0d]", i));

    // load-use lasts one cycle: bubble clears MemRead, ID proceeds
    run_cycle(mk(1, 1, 8, 8, 0, 0, 0, 0, 0, 0), 6'b000100, 0, "lu_stall");
    run_cycle(mk(1, 0, 0, 8, 0, 0, 0, 0, 0, 0), 6'b110000, 0, "lu_release");
    // branch over load-use: no stall on the following cycle
    run_cycle(mk(1, 1, 8, 8, 0, 0, 0, 0, 0, 1), 6'b111100, 0, "br_over_lu");
    run_cycle(mk(1, 0, 0, 8, 0, 0, 0, 0, 0, 0), 6'b110000, 0, "br_after");

    // mult/div issued at T, mfhi held in ID
    run_cycle(st,   6'b110000, 0, "md_T");
    run_cycle(hilo, 6'b000110, 0, "md_T+1");
    run_cycle(hilo, 6'b000110, 0, "md_T+2");
    run_cycle(hilo, 6'b000110, 0, "md_T+3");
    run_cycle(hilo, 6'b000111, 0, "md_T+4_done");
    run_cycle(hilo, 6'b110000, 0, "md_T+5_go");

    // start while busy is ignored; a branch does not cancel the operation
    run_cycle(st,  6'b110000, 0, "viol_T");
    run_cycle(st,  6'b110010, 0, "viol_T+1");
    run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), 6'b111110, 0, "viol_br");
    run_cycle(nop, 6'b110010, 0, "viol_T+3");
    run_cycle(nop, 6'b110011, 0, "viol_done");
    run_cycle(nop, 6'b110000, 0, "viol_idle");

    // reset at T+2 abandons the op; a fresh start gets the full count
    run_cycle(st,  6'b110000, 0, "rst_T");
    run_cycle(nop, 6'b110010, 0, "rst_T+1");
    run_cycle(rst, 6'b001100, 0, "rst_T+2");
    run_cycle(nop, 6'b110000, 0, "rst_T+3");
    run_cycle(st,  6'b110000, 0, "restart");
    for (int i = 0; i < MD_CYCLES - 1; i++) run_cycle(nop, 6'b110010, 0, "restart_busy");
    run_cycle(nop, 6'b110011, 0, "restart_done");
    run_cycle(nop, 6'b110000, 0, "restart_idle");

`ifdef HAZARD_PERF_CNT_EN
    run_cycle(rst, 6'b001100, 0, "perf_rst");
    for (int i = 0; i < 3; i++) run_cycle(mk(1, 1, 9, 9, 0, 0, 0, 0, 0, 0), 6'b000100, 0, "perf_stall");
    for (int i = 0; i < 2; i++) run_cycle(mk(1, 1, 9, 9, 0, 0, 0, 0, 0, 1), 6'b111100, 0, "perf_br");
    check("perf_stall_cycles", stall_cycles, 32'd3);
    check("perf_flush_cycles", flush_cycles, 32'd2);
`endif

    for (int i = 0; i < 400; i++) begin
      vec_t v;
      v.rst_n      = ($urandom_range(0, 39) != 0);
      v.mem_read   = $urandom_range(0, 1) == 1;
      v.idex_rt    = 5'($urandom_range(0, 3));
      v.rs         = 5'($urandom_range(0, 3));
      v.rt         = 5'($urandom_range(0, 3));
      v.uses_rt    = $urandom_range(0, 1) == 1;
      v.is_md      = $urandom_range(0, 3) == 0;
      v.reads_hilo = $urandom_range(0, 3) == 0;
      v.md_start   = (model_rem == 0) && ($urandom_range(0, 3) == 0);
      v.br         = $urandom_range(0, 7) == 0;
      run_cycle(v, 6'b0, 1, "random");
    end

`ifdef HAZARD_PERF_CNT_EN
    check("rand_stall_cycles", stall_cycles, model_stall);
    check("rand_flush_cycles", flush_cycles, model_flush);
`endif
    check("protocol_violations_seen", proto_viol, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Sequences the 5-stage MIPS pipeline around hazards that operand forwarding cannot resolve.
- Detects load-use dependencies and taken branches in EX.
- Tracks occupancy of the multi-cycle mult/div unit.
- Drives the PC write-enable, the IF/ID write-enable, the IF/ID flush and the ID/EX bubble-insert controls. Sits beside the forwarding logic in the ID/EX control path.

Parameters:
- MD_CYCLES, 32, cycles the mult/div unit is occupied per operation (≥2).
- CNT_W, 6, mult/div countdown width; must satisfy 2^CNT_W > MD_CYCLES.
- PERF_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, synchronous, active-low
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_RegRt  in  5  load destination register in EX
- IFID_RegRs  in  5  rs field of the instruction in ID
- IFID_RegRt  in  5  rt field of the instruction in ID
- IFID_UsesRt  in  1  instruction in ID reads rt as a source
- IFID_IsMd  in  1  instruction in ID is mult/multu/div/divu
- IFID_ReadsHiLo  in  1  instruction in ID is mfhi/mflo
- IDEX_MdStart  in  1  mult/div issues in EX this cycle
- EX_BranchTaken  in  1  branch/jump resolved taken in EX
- PC_Write  out  1  PC register load enable
- IFID_Write  out  1  IF/ID register load enable
- IFID_Flush  out  1  clear IF/ID to nop
- IDEX_Bubble  out  1  load nop controls into ID/EX
- md_busy  out  1  mult/div unit occupied
- md_done  out  1  single-cycle pulse on the last busy cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset:
  - While rst_n=0 at a clk edge, the state goes to MD_IDLE and the counter to 0.
  - During reset, outputs are forced to PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, md_busy=0, md_done=0.
  - Reset asserted mid-operation abandons the operation. No md_done is produced.
- Mult/div FSM (registered):
  - States are MD_IDLE and MD_BUSY.
  - MD_IDLE goes to MD_BUSY on IDEX_MdStart; the counter loads MD_CYCLES-1.
  - In MD_BUSY the counter decrements each cycle.
  - When the counter reaches 0: md_done=1 for that cycle, and the next state is MD_IDLE.
  - md_busy=1 exactly when the state is MD_BUSY.
  - IDEX_MdStart asserted in MD_BUSY is a protocol violation. The controller ignores it, and the bench assertion must flag it.
- Hazard terms (combinational from current inputs and state; zero latency):
  - load_use = IDEX_MemRead & IDEX_RegRt≠0 & (IDEX_RegRt==IFID_RegRs | (IFID_UsesRt & IDEX_RegRt==IFID_RegRt)).
  - md_stall = md_busy & (IFID_IsMd | IFID_ReadsHiLo). This includes the md_done cycle.
  - stall = load_use | md_stall.
- Output priority (highest first):
  - EX_BranchTaken: PC_Write=1, IFID_Write=1, IFID_Flush=1, IDEX_Bubble=1. This overrides any stall, because the instruction in ID is squashed.
  - stall: PC_Write=0, IFID_Write=0, IFID_Flush=0, IDEX_Bubble=1.
  - Otherwise: PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0.
- Stall duration:
  - A load-use stall lasts exactly 1 cycle, because the bubble clears IDEX_MemRead.
  - An md_stall lasts until the cycle after md_done.
- Flushes never cancel an in-flight mult/div. The FSM keeps counting.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles and flush_cycles (PERF_W each).
  - stall_cycles increments on each cycle with stall=1 and EX_BranchTaken=0.
  - flush_cycles increments on each cycle with EX_BranchTaken=1.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - the md_state_t enum (MD_IDLE, MD_BUSY);
  - REG_ZERO=5'd0;
  - REG_ADDR_W=5.
- One sub-module, md_busy_tracker: the FSM plus counter, producing md_busy and md_done.
- Hazard and priority logic stay in the top module.

Test Plan:
- Load-use: lw $8 in EX, ID reads rs=$8 → exactly 1 cycle of PC_Write=0, IFID_Write=0, IDEX_Bubble=1; the next cycle is normal.
- Load to $0, or rt match with IFID_UsesRt=0 → no stall.
- IDEX_MdStart at cycle T with MD_CYCLES=4:
  - md_busy=1 for T+1..T+4;
  - md_done=1 only at T+4;
  - mfhi held in ID stalls T+1..T+4 and proceeds at T+5.
- EX_BranchTaken with a simultaneous load_use → IFID_Flush=1, PC_Write=1, IDEX_Bubble=1; no stall the following cycle.
- rst_n=0 at T+2 of a mult/div → next cycle md_busy=0 and no md_done pulse; a fresh IDEX_MdStart restarts the full count.
- With HAZARD_PERF_CNT_EN: 3 stall cycles and 2 taken branches → stall_cycles=3, flush_cycles=2.
